// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encoding,
// default timeout settings and an index-width helper.
package uart_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    PASS = 1'b1
  } arb_state_e;

  localparam int DEF_TIMEOUT_CYC = 100000;
  localparam int DEF_CNT_W       = 16;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin selector: the first active request after
// the pointer position wins, wrapping modulo NUM_REQ.
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] winner,
  output logic [IDX_W-1:0]   idx,
  output logic               any_req
);

  logic [IDX_W-1:0] scan;

  // The pointer holds the previous owner, so scanning starts one past it
  // and the previous owner itself is considered last.
  always_comb begin
    winner  = '0;
    idx     = '0;
    any_req = 1'b0;
    scan    = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      scan = IDX_W'((int'(ptr) + i) % NUM_REQ);
      if (!any_req && req[scan]) begin
        any_req      = 1'b1;
        idx          = scan;
        winner[scan] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter sharing one UART transmit byte stream
// between several message sources, with a mid-packet stall timeout.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ-1:0]          req_last,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [DATA_W-1:0]           tx_data,
  output logic                        tx_valid,
  input  logic                        tx_ready,
  output logic [NUM_REQ-1:0]          grant,
  output logic                        busy,
  output logic                        timeout_pulse,
  output logic [CNT_W-1:0]            timeout_count
);

  localparam int IDX_W = idx_width(NUM_REQ);
  localparam int TO_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  arb_state_e          state, state_nxt;
  logic [NUM_REQ-1:0]  grant_nxt;
  logic [IDX_W-1:0]    gidx, gidx_nxt;
  logic [IDX_W-1:0]    ptr, ptr_nxt;
  logic [TO_W-1:0]     to_cnt, to_cnt_nxt;
  logic                pulse_nxt;
  logic [CNT_W-1:0]    tcount_nxt;

  logic [NUM_REQ-1:0]  pick_onehot;
  logic [IDX_W-1:0]    pick_idx;
  logic                pick_any;

  logic [DATA_W-1:0]   req_bytes [NUM_REQ];
  logic                g_valid;
  logic                g_last;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_split
    assign req_bytes[i] = req_data[i*DATA_W +: DATA_W];
  end

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req     (req_valid),
    .ptr     (ptr),
    .winner  (pick_onehot),
    .idx     (pick_idx),
    .any_req (pick_any)
  );

  assign g_valid = req_valid[gidx];
  assign g_last  = req_last[gidx];

  // The granted requester is wired straight through; everything is forced
  // to zero while idle so a stale index can never leak a byte.
  assign busy      = (state == PASS);
  assign tx_valid  = busy & g_valid;
  assign tx_data   = busy ? req_bytes[gidx] : '0;
  assign req_ready = (busy && tx_ready) ? grant : '0;

  always_comb begin
    state_nxt  = state;
    grant_nxt  = grant;
    gidx_nxt   = gidx;
    ptr_nxt    = ptr;
    to_cnt_nxt = to_cnt;
    pulse_nxt  = 1'b0;
    tcount_nxt = timeout_count;
    unique case (state)
      IDLE: begin
        if (pick_any) begin
          state_nxt  = PASS;
          grant_nxt  = pick_onehot;
          gidx_nxt   = pick_idx;
          to_cnt_nxt = '0;
        end
      end
      PASS: begin
        if (g_valid) begin
          to_cnt_nxt = '0;
          if (tx_ready && g_last) begin
            state_nxt = IDLE;
            grant_nxt = '0;
            ptr_nxt   = gidx;
          end
        end else if (TIMEOUT_CYC > 0) begin
          // A stalled owner is dropped so it cannot lock out the others.
          if (to_cnt == TO_LAST) begin
            state_nxt  = IDLE;
            grant_nxt  = '0;
            ptr_nxt    = gidx;
            to_cnt_nxt = '0;
            pulse_nxt  = 1'b1;
            if (timeout_count != {CNT_W{1'b1}}) begin
              tcount_nxt = timeout_count + CNT_W'(1);
            end
          end else begin
            to_cnt_nxt = to_cnt + TO_W'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      grant         <= '0;
      gidx          <= '0;
      ptr           <= IDX_W'(NUM_REQ - 1);
      to_cnt        <= '0;
      timeout_pulse <= 1'b0;
      timeout_count <= '0;
    end else begin
      state         <= state_nxt;
      grant         <= grant_nxt;
      gidx          <= gidx_nxt;
      ptr           <= ptr_nxt;
      to_cnt        <= to_cnt_nxt;
      timeout_pulse <= pulse_nxt;
      timeout_count <= tcount_nxt;
    end
  end

endmodule
